// File: rtl/path_pkg.sv
// Shared widths, limits and state encoding for the path sequencer.
package path_pkg;

    localparam int NODE_W = 5;
    localparam int DEPTH  = 16;
    localparam int SEG_W  = 4;
    localparam int CNT_W  = 5;

    localparam logic [NODE_W-1:0] NODE_NONE = 5'd31;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = 5'd16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        ISSUE  = 3'd2,
        TRAVEL = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    function automatic logic is_busy_state(input seq_state_t s);
        return (s == ISSUE) || (s == TRAVEL);
    endfunction

endpackage

// File: rtl/path_sequencer_if.sv
// Planner-to-sequencer node stream (valid/ready with end-of-path marker).
interface path_sequencer_if;

    logic                      plan_valid;
    logic [path_pkg::NODE_W-1:0] plan_node;
    logic                      plan_last;
    logic                      plan_ready;

    modport master (output plan_valid, output plan_node, output plan_last, input plan_ready);
    modport slave  (input plan_valid, input plan_node, input plan_last, output plan_ready);

endinterface

// File: rtl/node_arrival_det.sv
// node_flag rising-edge detector gated by a post-issue holdoff counter.
module node_arrival_det #(
    parameter int HOLDOFF = 3125
) (
    input  logic clk_3125KHz,
    input  logic reset,
    input  logic node_flag,
    input  logic arm,
    output logic arrive
);

    localparam int HO_W = $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0] HOLDOFF_LD = HO_W'(HOLDOFF);
    localparam logic [HO_W-1:0] HO_ONE     = HO_W'(1);

    logic [HO_W-1:0] holdoff_q, holdoff_d;
    logic            flag_prev_q, flag_prev_d;

    // Next holdoff value and edge-detector history; history tracks even during holdoff
    always_comb begin
        flag_prev_d = node_flag;
        if (arm) begin
            holdoff_d = HOLDOFF_LD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_ONE;
        end else begin
            holdoff_d = holdoff_q;
        end
    end

    // Holdoff and edge-detector registers
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            holdoff_q   <= '0;
            flag_prev_q <= 1'b0;
        end else begin
            holdoff_q   <= holdoff_d;
            flag_prev_q <= flag_prev_d;
        end
    end

    assign arrive = node_flag & ~flag_prev_q & (holdoff_q == '0);

endmodule

// File: rtl/path_sequencer.sv
// Buffers a planned node list and issues one (curr,next) segment per
// node arrival until the final node is reached.
module path_sequencer
    import path_pkg::*;
#(
    parameter int HOLDOFF = 3125
) (
    input  logic              clk_3125KHz,
    input  logic              reset,
    path_sequencer_if.slave   plan,
    input  logic              cpu_start,
    input  logic              abort,
    input  logic              node_flag,
    output logic              node_changed,
    output logic [NODE_W-1:0] curr_node,
    output logic [NODE_W-1:0] next_node,
    output logic [NODE_W-1:0] realtime_pos,
    output logic [SEG_W-1:0]  seg_idx,
    output logic              busy,
    output logic              run_done,
    output logic              err
);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEG_W-1:0]  seg_idx_q, seg_idx_d;
    logic [NODE_W-1:0] node_buf_q [DEPTH];
    logic [NODE_W-1:0] node_buf_d [DEPTH];
    logic              start_prev_q;
    logic [NODE_W-1:0] curr_node_q, curr_node_d;
    logic [NODE_W-1:0] next_node_q, next_node_d;
    logic [NODE_W-1:0] realtime_pos_q, realtime_pos_d;
    logic              node_changed_q, node_changed_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic              err_q, err_d;

    logic              plan_ready_s;
    logic              accept_s;
    logic              full_drop_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              short_last_s;
    logic              load_done_s;
    logic              start_rise_s;
    logic              arrive_s;
    logic              arm_s;
    logic [SEG_W-1:0]  seg_next_s;
    logic              last_seg_s;

    assign plan_ready_s = (state_q == IDLE) && (count_q < DEPTH_CNT) && !reset;
    assign accept_s     = plan.plan_valid & plan_ready_s;
    assign full_drop_s  = (state_q == IDLE) & plan.plan_valid & (count_q == DEPTH_CNT);
    assign count_inc_s  = count_q + 5'd1;
    assign short_last_s = accept_s & plan.plan_last & (count_inc_s < 5'd2);
    // A plan_last arriving on a full buffer still closes the (truncated) path
    assign load_done_s  = (accept_s & plan.plan_last & (count_inc_s >= 5'd2))
                        | (full_drop_s & plan.plan_last);
    assign start_rise_s = cpu_start & ~start_prev_q;
    assign arm_s        = (state_q == ISSUE);
    assign seg_next_s   = seg_idx_q + 4'd1;
    assign last_seg_s   = ({1'b0, seg_next_s} == (count_q - 5'd1));

    node_arrival_det #(
        .HOLDOFF (HOLDOFF)
    ) u_arrival (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .node_flag   (node_flag),
        .arm         (arm_s),
        .arrive      (arrive_s)
    );

    // State register
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = load_done_s ? LOADED : IDLE;
                LOADED:  state_d = start_rise_s ? ISSUE : LOADED;
                ISSUE:   state_d = TRAVEL;
                TRAVEL: begin
                    if (arrive_s) begin
                        state_d = last_seg_s ? DONE : ISSUE;
                    end else begin
                        state_d = TRAVEL;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        count_d        = count_q;
        seg_idx_d      = seg_idx_q;
        node_buf_d     = node_buf_q;
        curr_node_d    = curr_node_q;
        next_node_d    = next_node_q;
        realtime_pos_d = realtime_pos_q;
        node_changed_d = 1'b0;
        err_d          = err_q;
        if (abort) begin
            count_d   = 5'd0;
            seg_idx_d = 4'd0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        node_buf_d[count_q[SEG_W-1:0]] = plan.plan_node;
                        count_d = short_last_s ? 5'd0 : count_inc_s;
                    end else begin
                        count_d = count_q;
                    end
                    if (short_last_s || full_drop_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                LOADED: begin
                    if (start_rise_s) begin
                        seg_idx_d = 4'd0;
                    end else begin
                        seg_idx_d = seg_idx_q;
                    end
                end
                ISSUE: begin
                    curr_node_d    = node_buf_q[seg_idx_q];
                    next_node_d    = node_buf_q[seg_next_s];
                    node_changed_d = 1'b1;
                end
                TRAVEL: begin
                    if (arrive_s) begin
                        realtime_pos_d = next_node_q;
                        seg_idx_d      = seg_next_s;
                    end else begin
                        seg_idx_d      = seg_idx_q;
                    end
                end
                DONE:    seg_idx_d = seg_idx_q;
                default: seg_idx_d = seg_idx_q;
            endcase
        end
        busy_d     = is_busy_state(state_d);
        run_done_d = (state_d == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            count_q        <= 5'd0;
            seg_idx_q      <= 4'd0;
            node_buf_q     <= '{default: '0};
            start_prev_q   <= 1'b0;
            curr_node_q    <= NODE_NONE;
            next_node_q    <= NODE_NONE;
            realtime_pos_q <= NODE_NONE;
            node_changed_q <= 1'b0;
            busy_q         <= 1'b0;
            run_done_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            count_q        <= count_d;
            seg_idx_q      <= seg_idx_d;
            node_buf_q     <= node_buf_d;
            start_prev_q   <= cpu_start;
            curr_node_q    <= curr_node_d;
            next_node_q    <= next_node_d;
            realtime_pos_q <= realtime_pos_d;
            node_changed_q <= node_changed_d;
            busy_q         <= busy_d;
            run_done_q     <= run_done_d;
            err_q          <= err_d;
        end
    end

    assign plan.plan_ready = plan_ready_s;
    assign node_changed    = node_changed_q;
    assign curr_node       = curr_node_q;
    assign next_node       = next_node_q;
    assign realtime_pos    = realtime_pos_q;
    assign seg_idx         = seg_idx_q;
    assign busy            = busy_q;
    assign run_done        = run_done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Self-checking bench for path_sequencer: table-driven load phase plus
// scoreboarded segment issues for run, holdoff, overflow, short-path and abort cases.
module tb_path_sequencer;

    localparam int HO = 4;

    logic       clk_3125KHz = 1'b0;
    logic       reset, cpu_start, abort, node_flag;
    logic       node_changed;
    logic [4:0] curr_node, next_node, realtime_pos;
    logic [3:0] seg_idx;
    logic       busy, run_done, err;

    path_sequencer_if pif ();

    path_sequencer #(.HOLDOFF(HO)) dut (
        .clk_3125KHz  (clk_3125KHz),
        .reset        (reset),
        .plan         (pif),
        .cpu_start    (cpu_start),
        .abort        (abort),
        .node_flag    (node_flag),
        .node_changed (node_changed),
        .curr_node    (curr_node),
        .next_node    (next_node),
        .realtime_pos (realtime_pos),
        .seg_idx      (seg_idx),
        .busy         (busy),
        .run_done     (run_done),
        .err          (err)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    typedef struct packed {
        logic [4:0] c;
        logic [4:0] n;
        logic [3:0] s;
    } pair_t;

    typedef struct {
        logic       valid;
        logic [4:0] node;
        logic       last;
        logic       exp_err;
        logic       exp_ready;
    } load_vec_t;

    pair_t      exp_q[$];
    load_vec_t  vecs[5];
    int         n_cmp = 0;
    int         n_err = 0;
    int         nc_total = 0;
    logic       nc_now = 1'b0;
    logic [4:0] m_buf[18];
    int         m_count = 0;
    logic       m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        pair_t e;
        @(posedge clk_3125KHz);
        #1;
        nc_now = node_changed;
        if (node_changed) begin
            nc_total++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_node_changed: got pulse curr=%0d next=%0d, required none", curr_node, next_node);
            end else begin
                e = exp_q.pop_front();
                check("pair_curr", curr_node, e.c);
                check("pair_next", next_node, e.n);
                check("pair_seg", seg_idx, e.s);
            end
        end
    endtask

    task automatic wait_nc(input int lat);
        int cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!nc_now && cyc < 20);
        if (!nc_now) begin
            n_cmp++;
            n_err++;
            $display("FAIL nc_timeout: got no node_changed in %0d cycles, required one", cyc);
        end else begin
            check("nc_latency", cyc, lat);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic drive_plan(input logic v, input logic [4:0] nd, input logic l);
        logic acc;
        pif.plan_valid = v;
        pif.plan_node  = nd;
        pif.plan_last  = l;
        acc = v && (m_count < 16);
        check("plan_ready_pre", pif.plan_ready, (m_count < 16));
        if (acc) begin
            m_buf[m_count] = nd;
            m_count++;
        end else if (v) begin
            m_err = 1'b1;
        end
        if (v && l && acc && m_count < 2) begin
            m_err   = 1'b1;
            m_count = 0;
        end
        tick();
        pif.plan_valid = 1'b0;
        pif.plan_last  = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] cn, input logic [4:0] nn);
        exp_q.push_back('{c: cn, n: nn, s: 4'd0});
        cpu_start = 1'b1;
        tick();
        check("nc_not_early", node_changed, 1'b0);
        check("busy_after_start", busy, 1'b1);
        cpu_start = 1'b0;
        wait_nc(1);
        check("busy_at_issue", busy, 1'b1);
    endtask

    task automatic arrive_at(input logic [4:0] reached, input logic [4:0] nxt,
                             input logic [3:0] seg_new, input logic last);
        repeat (9) tick();
        if (!last) exp_q.push_back('{c: reached, n: nxt, s: seg_new});
        node_flag = 1'b1;
        tick();
        node_flag = 1'b0;
        check("realtime_pos_arrive", realtime_pos, reached);
        check("seg_idx_arrive", seg_idx, seg_new);
        if (last) begin
            check("run_done_final", run_done, 1'b1);
            check("busy_final", busy, 1'b0);
        end else begin
            wait_nc(1);
        end
    endtask

    task automatic run_path();
        do_start(m_buf[0], m_buf[1]);
        for (int s = 1; s < m_count; s++) begin
            arrive_at(m_buf[s], m_buf[s+1], 4'(s), s == m_count - 1);
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_clear();
        check("abort_busy", busy, 1'b0);
        check("abort_run_done", run_done, 1'b0);
        check("abort_err", err, 1'b0);
        check("abort_ready", pif.plan_ready, 1'b1);
        check("abort_seg", seg_idx, 4'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_node_changed", node_changed, 1'b0);
        check("rst_curr", curr_node, 5'd31);
        check("rst_next", next_node, 5'd31);
        check("rst_pos", realtime_pos, 5'd31);
        check("rst_seg", seg_idx, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", run_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", pif.plan_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required bounded run", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{valid: 1'b0, node: 5'd7,  last: 1'b1, exp_err: 1'b0, exp_ready: 1'b1};
        vecs[1] = '{valid: 1'b1, node: 5'd0,  last: 1'b0, exp_err: 1'b0, exp_ready: 1'b1};
        vecs[2] = '{valid: 1'b1, node: 5'd1,  last: 1'b0, exp_err: 1'b0, exp_ready: 1'b1};
        vecs[3] = '{valid: 1'b1, node: 5'd29, last: 1'b0, exp_err: 1'b0, exp_ready: 1'b1};
        vecs[4] = '{valid: 1'b1, node: 5'd20, last: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};

        reset = 1'b1; cpu_start = 1'b0; abort = 1'b0; node_flag = 1'b0;
        pif.plan_valid = 1'b0; pif.plan_node = 5'd0; pif.plan_last = 1'b0;
        repeat (2) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        check("ready_after_reset", pif.plan_ready, 1'b1);

        // Load 0,1,29,20 with cpu_start already high: entering LOADED must not start
        cpu_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_plan(vecs[i].valid, vecs[i].node, vecs[i].last);
            check("tbl_err", err, vecs[i].exp_err);
            check("tbl_ready", pif.plan_ready, vecs[i].exp_ready);
        end
        repeat (3) tick();
        check("no_start_on_level", busy, 1'b0);
        check("no_issue_on_level", nc_total, 0);
        cpu_start = 1'b0;
        tick();
        run_path();

        // DONE ignores node_flag and cpu_start
        repeat (9) tick();
        node_flag = 1'b1; tick(); node_flag = 1'b0;
        cpu_start = 1'b1; tick(); cpu_start = 1'b0;
        repeat (5) tick();
        check("done_no_issue", nc_total, 3);
        check("done_held", run_done, 1'b1);
        check("done_pos", realtime_pos, 5'd20);

        // Holdoff: level held across expiry is not an arrival
        do_abort();
        check("abort_keeps_pos", realtime_pos, 5'd20);
        drive_plan(1'b1, 5'd3, 1'b0);
        drive_plan(1'b1, 5'd7, 1'b0);
        drive_plan(1'b1, 5'd9, 1'b1);
        do_start(5'd3, 5'd7);
        tick();
        node_flag = 1'b1;
        repeat (8) tick();
        node_flag = 1'b0;
        tick();
        check("held_level_pos", realtime_pos, 5'd20);
        check("held_level_seg", seg_idx, 4'd0);
        check("held_level_nc", nc_total, 4);
        exp_q.push_back('{c: 5'd7, n: 5'd9, s: 4'd1});
        node_flag = 1'b1; tick(); node_flag = 1'b0;
        check("fresh_edge_pos", realtime_pos, 5'd7);
        wait_nc(1);

        // Overflow: 17 nodes, last one dropped, 16-node path runs 15 segments
        do_abort();
        for (int i = 0; i < 17; i++) begin
            drive_plan(1'b1, 5'((i * 7) % 30), i == 16);
        end
        check("ovf_err", err, m_err);
        check("ovf_ready", pif.plan_ready, 1'b0);
        check("ovf_count_model", m_count, 16);
        run_path();
        check("ovf_err_sticky", err, 1'b1);

        // Single-node path: error, stay IDLE with count cleared
        do_abort();
        drive_plan(1'b1, 5'd5, 1'b1);
        check("short_err", err, 1'b1);
        check("short_ready", pif.plan_ready, 1'b1);
        check("short_busy", busy, 1'b0);
        drive_plan(1'b1, 5'd8, 1'b0);
        drive_plan(1'b1, 5'd9, 1'b1);
        check("short_reload_ready", pif.plan_ready, 1'b0);
        run_path();

        // Abort during TRAVEL of segment 1
        do_abort();
        drive_plan(1'b1, 5'd2, 1'b0);
        drive_plan(1'b1, 5'd4, 1'b0);
        drive_plan(1'b1, 5'd6, 1'b0);
        drive_plan(1'b1, 5'd8, 1'b1);
        do_start(5'd2, 5'd4);
        arrive_at(5'd4, 5'd6, 4'd1, 1'b0);
        repeat (2) tick();
        do_abort();
        check("travel_abort_pos", realtime_pos, 5'd4);

        // Reset together with abort
        drive_plan(1'b1, 5'd11, 1'b0);
        reset = 1'b1;
        abort = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        abort = 1'b0;
        model_clear();
        tick();
        check("post_reset_ready", pif.plan_ready, 1'b1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
